// File: rtl/receive_pkg.sv
// rtl/receive_pkg.sv - shared FSM states and constants for the serial receiver (RECEIVE_PARITY_EN adds PARITY)
package receive_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RECEIVE_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer for the asynchronous serial line
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // two-stage metastability filter; reset loads the line's idle level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/receive.sv
// rtl/receive.sv - 8N1 serial receiver; RECEIVE_PARITY_EN adds an even-parity bit and parity_err
module receive
  import receive_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       valid,
  output logic       frame_err
`ifdef RECEIVE_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  logic                 w_rx;
  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [CW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_brk;
  logic                 w_full;
  logic                 w_timer_clr;
  logic                 w_shift_en;
  logic                 w_load;
  logic                 w_ferr_set;
  logic                 w_brk_set;
`ifdef RECEIVE_PARITY_EN
  logic                 r_par;
  logic                 r_perr;
  logic                 w_par_en;
  logic                 w_perr_set;
`endif

  rx_sync #(
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  (rxd),
    .o_q  (w_rx)
  );

  assign w_full = (r_timer == T_FULL);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and per-cycle control decisions, all taken on the synchronized line
  always_comb begin
    w_state_nxt = r_state;
    w_timer_clr = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr_set  = 1'b0;
    w_brk_set   = 1'b0;
`ifdef RECEIVE_PARITY_EN
    w_par_en    = 1'b0;
    w_perr_set  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_rx != IDLE_LEVEL) begin
          w_state_nxt = START;
          w_timer_clr = 1'b1;
        end
      end
      START: begin
        if (r_timer == T_HALF) begin
          w_timer_clr = 1'b1;
          w_state_nxt = (w_rx != IDLE_LEVEL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (w_full) begin
          w_timer_clr = 1'b1;
          w_shift_en  = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef RECEIVE_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef RECEIVE_PARITY_EN
      PARITY: begin
        if (w_full) begin
          w_timer_clr = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (r_brk) begin
          // a held break must release before another start can be hunted
          if (w_rx == IDLE_LEVEL) begin
            w_state_nxt = IDLE;
          end
        end else if (w_full) begin
          w_timer_clr = 1'b1;
          if (w_rx == IDLE_LEVEL) begin
            w_state_nxt = IDLE;
`ifdef RECEIVE_PARITY_EN
            if ((^r_shift) != r_par) begin
              w_perr_set = 1'b1;
            end else begin
              w_load = 1'b1;
            end
`else
            w_load = 1'b1;
`endif
          end else begin
            w_ferr_set = 1'b1;
            w_brk_set  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // bit timer, bit counter, shift register, output word and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_brk     <= 1'b0;
    end else begin
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (r_state != IDLE && !r_brk) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
      end
      if (w_load) begin
        r_word <= r_shift;
      end
      r_valid <= w_load;
      r_ferr  <= w_ferr_set;
      r_brk   <= w_brk_set | (r_brk & (w_state_nxt == STOP));
    end
  end

`ifdef RECEIVE_PARITY_EN
  // captured parity bit and its error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_par_en) begin
        r_par <= w_rx;
      end
      r_perr <= w_perr_set;
    end
  end

  assign parity_err = r_perr;
`endif

  assign word      = r_word;
  assign valid     = r_valid;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_receive.sv
// tb/tb_receive.sv - scoreboard bench for receive with randomized frames (RECEIVE_PARITY_EN aware)
module tb_receive;

  localparam int CPB = 16;
`ifdef RECEIVE_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // stop-bit midpoint plus two synchronizer flops plus start detect
  localparam int LATENCY = (FRAME_BITS - 1) * CPB + CPB / 2 + 3;

  typedef struct {
    int         kind;   // 1 valid, 2 frame_err, 3 parity_err
    logic [7:0] w;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] word;
  logic       valid;
  logic       frame_err;
  logic       perr_mon;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         v_prev = 0;
  int         v_last = 0;
  logic [7:0] model_word = 8'h00;
  exp_t       sbq[$];
  exp_t       m_e;
  int         m_kind;
  int         m_hits;

`ifdef RECEIVE_PARITY_EN
  logic parity_err;
  assign perr_mon = parity_err;
  receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .word      (word),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );
`else
  assign perr_mon = 1'b0;
  receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .word     (word),
    .valid    (valid),
    .frame_err(frame_err)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  // monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && (valid === 1'b1 || frame_err === 1'b1 || perr_mon === 1'b1)) begin
      m_hits = int'(valid === 1'b1) + int'(frame_err === 1'b1) + int'(perr_mon === 1'b1);
      chk("single_pulse", m_hits, 1);
      m_kind = (valid === 1'b1) ? 1 : (frame_err === 1'b1) ? 2 : 3;
      if (valid === 1'b1) begin
        v_prev = v_last;
        v_last = cyc;
      end
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: kind %0d word 0x%0h at cycle %0d, none expected", m_kind, word, cyc);
      end else begin
        m_e = sbq.pop_front();
        chk("pulse_kind", m_kind, m_e.kind);
        chk("word", int'(word), int'(m_e.w));
        chk("latency", cyc - m_e.t0, LATENCY);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  // stop_low > 0 holds the stop bit low that many bit periods; rst_bit >= 0 aborts mid data bit
  task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_flip, input int rst_bit);
    exp_t e;
    e.t0 = cyc;
    if (rst_bit < 0) begin
      if (stop_low > 0) begin
        e.kind = 2;
        e.w    = model_word;
      end else if (par_flip) begin
        e.kind = 3;
        e.w    = model_word;
      end else begin
        e.kind     = 1;
        e.w        = d;
        model_word = d;
      end
      sbq.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rxd = d[i];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_word = 8'h00;
        return;
      end
      drive_bit(d[i]);
    end
`ifdef RECEIVE_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    if (stop_low > 0) begin
      rxd = 1'b0;
      repeat (stop_low * CPB) @(posedge clk);
      #1;
      drive_bit(1'b1);
    end else begin
      drive_bit(1'b1);
    end
  endtask

  task automatic glitch(input int len);
    rxd = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations outstanding", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         r;
    int         sl;
    logic       pf;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_word", int'(word), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(perr_mon), 0);
    rst = 1'b0;
    idle_bits(2);

    send_frame(8'h81, 0, 1'b0, -1);
    idle_bits(2);
    chk("word_81", int'(word), 8'h81);

    send_frame(8'h81, 0, 1'b0, -1);
    send_frame(8'h00, 0, 1'b0, -1);
    idle_bits(1);
    chk("b2b_interval", v_last - v_prev, FRAME_BITS * CPB);
    chk("word_00", int'(word), 8'h00);

    glitch(4);
    idle_bits(1);
    chk("glitch_word", int'(word), 8'h00);

    send_frame(8'h55, 3, 1'b0, -1);
    idle_bits(1);
    chk("break_word", int'(word), 8'h00);
    send_frame(8'h66, 0, 1'b0, -1);
    idle_bits(1);

    send_frame(8'hA5, 0, 1'b0, 3);
    chk("abort_word", int'(word), 0);
    chk("abort_valid", int'(valid), 0);
    idle_bits(1);
    send_frame(8'h3C, 0, 1'b0, -1);
    idle_bits(1);
    chk("word_3c", int'(word), 8'h3C);

`ifdef RECEIVE_PARITY_EN
    send_frame(8'h07, 0, 1'b1, -1);
    idle_bits(1);
    chk("parity_bad_word", int'(word), 8'h3C);
    send_frame(8'h07, 0, 1'b0, -1);
    idle_bits(1);
    chk("parity_good_word", int'(word), 8'h07);
`endif

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      d  = 8'($urandom);
      sl = (r == 1) ? $urandom_range(1, 3) : 0;
`ifdef RECEIVE_PARITY_EN
      pf = (r == 2);
`else
      pf = 1'b0;
`endif
      if (r == 0) begin
        glitch($urandom_range(1, 5));
      end else begin
        send_frame(d, sl, pf, -1);
        if (sl > 0) idle_bits(1);
      end
      idle_bits($urandom_range(0, 2));
    end

    for (int t = 0; t < 4 * FRAME_BITS * CPB && sbq.size() != 0; t++) begin
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    chk("final_word", int'(word), int'(model_word));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
